// File: rtl/memory_responder.sv
// -----------------------------------------------------------------------------
// memory_responder
//
// Word-addressed 24-bit memory slave with a one-stage registered read pipeline
// and an in-order response queue.
//
// Handshake (both channels): a transfer happens on a rising edge where the
// sender's valid and the receiver's taken are both high. A sender holds its
// fields stable while valid is high and taken is low. Fields are ignored while
// valid is low.
//
// Ports
//   clock     : single clock, rising edge
//   reset     : asynchronous, active-low
//   msValid   : request valid from master
//   msTaken   : request accepted this cycle (when msValid also high)
//   msAddress : word address of request
//   msData    : write data
//   msID      : request tag, echoed in the response
//   msWrite   : 1 = write, 0 = read
//   smValid   : response valid to master
//   smTaken   : master accepts response (when smValid also high)
//   smData    : response data
//   smID      : response tag
//   busy      : a request is in the pipeline or the queue
// -----------------------------------------------------------------------------
module memory_responder #(
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int          DEPTH    = 1024,
  parameter int          QDEPTH   = 4,
  parameter logic [23:0] ERR_DATA = 24'hFFFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        msValid,
  output logic        msTaken,
  input  logic [31:0] msAddress,
  input  logic [23:0] msData,
  input  logic [7:0]  msID,
  input  logic        msWrite,
  output logic        smValid,
  input  logic        smTaken,
  output logic [23:0] smData,
  output logic [7:0]  smID,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  // Storage (not reset; contents survive reset)
  logic [23:0]   mem [DEPTH];

  // Request decode
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          accept;
  logic          pop;

  // Pipeline stage between acceptance and the queue
  logic          pipe_valid;
  logic [23:0]   pipe_data;
  logic [7:0]    pipe_id;

  // Response queue
  logic [23:0]   q_data [QDEPTH];
  logic [7:0]    q_id   [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] occupancy;

  // Offset arithmetic wraps, so addresses below BASE land far out of range.
  assign offset   = msAddress - BASE;
  assign in_range = (offset < 32'(DEPTH));
  assign word_idx = offset[AW-1:0];

  // Every accepted request occupies either the pipeline slot or a queue entry
  // until popped, so limiting their sum to QDEPTH guarantees the pipeline can
  // always push into the queue. Derived from registers only.
  assign occupancy = count + CW'(pipe_valid);
  assign msTaken   = reset && (occupancy < CW'(QDEPTH));

  assign accept  = msValid && msTaken;
  assign smValid = (count != '0);
  assign pop     = smValid && smTaken;
  assign smData  = q_data[rd_ptr];
  assign smID    = q_id[rd_ptr];
  assign busy    = pipe_valid || (count != '0);

  // Writes land on the accepting edge; out-of-range writes are dropped.
  always_ff @(posedge clock) begin
    if (accept && msWrite && in_range) begin
      mem[word_idx] <= msData;
    end
  end

  // Pipeline valid bit is reset; its payload need not be.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_valid <= 1'b0;
    end else begin
      pipe_valid <= accept;
    end
  end

  // Read happens at the accepting edge, which sees any write committed on an
  // earlier edge. Writes echo their own data.
  always_ff @(posedge clock) begin
    if (accept) begin
      pipe_id <= msID;
      if (msWrite) begin
        pipe_data <= msData;
      end else if (in_range) begin
        pipe_data <= mem[word_idx];
      end else begin
        pipe_data <= ERR_DATA;
      end
    end
  end

  // Queue payload storage
  always_ff @(posedge clock) begin
    if (pipe_valid) begin
      q_data[wr_ptr] <= pipe_data;
      q_id[wr_ptr]   <= pipe_id;
    end
  end

  // Queue pointers and count; QDEPTH is a power of two so pointers wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pipe_valid) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({pipe_valid, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_memory_responder
//
// Reference model: every accepted request is a pending response {data,id}
// tagged with the edge number it was accepted on. The head is visible from the
// edge after acceptance; msTaken/busy follow from the number of outstanding
// requests. Directed sequences pin the model with literal expectations, then a
// long randomized run with stalls is scored cycle by cycle.
// -----------------------------------------------------------------------------
module tb_memory_responder;

  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam int          DEPTH    = 64;
  localparam int          QDEPTH   = 4;
  localparam logic [23:0] ERR_DATA = 24'hFFFFFF;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        msValid = 1'b0;
  logic        msTaken;
  logic [31:0] msAddress = '0;
  logic [23:0] msData = '0;
  logic [7:0]  msID = '0;
  logic        msWrite = 1'b0;
  logic        smValid;
  logic        smTaken = 1'b0;
  logic [23:0] smData;
  logic [7:0]  smID;
  logic        busy;

  memory_responder #(
    .BASE(BASE), .DEPTH(DEPTH), .QDEPTH(QDEPTH), .ERR_DATA(ERR_DATA)
  ) dut (
    .clock(clock), .reset(reset),
    .msValid(msValid), .msTaken(msTaken), .msAddress(msAddress),
    .msData(msData), .msID(msID), .msWrite(msWrite),
    .smValid(smValid), .smTaken(smTaken), .smData(smData), .smID(smID),
    .busy(busy)
  );

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];      // pending responses {data, id}
  int          stamp_q[$];    // acceptance edge of each pending response
  logic [31:0] log_q[$];      // responses actually popped, for directed checks
  logic [23:0] mdl_mem [DEPTH];
  int          edge_n = 0;
  int          acc_count = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        acc;
  logic        pop;
  logic [31:0] pop_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] init_val(input int i);
    return (24'(i) * 24'h010101) ^ 24'h5A0000;
  endfunction

  // Response the specification requires for a request accepted now.
  function automatic logic [23:0] model_resp(input logic [31:0] a, input logic [23:0] d,
                                             input logic w);
    logic [31:0] off;
    off = a - BASE;
    if (w) return d;
    if (off < 32'(DEPTH)) return mdl_mem[off[5:0]];
    return ERR_DATA;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    int   outstanding;
    logic exp_valid;
    if (!reset) begin
      check("reset msTaken", 64'(msTaken), 64'(0));
      check("reset smValid", 64'(smValid), 64'(0));
      check("reset busy", 64'(busy), 64'(0));
    end else begin
      outstanding = exp_q.size();
      exp_valid   = (outstanding != 0) && (stamp_q[0] < edge_n);
      check("msTaken", 64'(msTaken), 64'(outstanding < QDEPTH));
      check("busy", 64'(busy), 64'(outstanding != 0));
      check("smValid", 64'(smValid), 64'(exp_valid));
      if (exp_valid && smValid) begin
        check("response", 64'({smData, smID}), 64'(exp_q[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic w, input logic [31:0] a,
                      input logic [23:0] d, input logic [7:0] id, input logic take);
    logic [31:0] off;
    @(negedge clock);
    #1;
    msValid = v; msWrite = w; msAddress = a; msData = d; msID = id; smTaken = take;
    #1;
    acc     = reset && msValid && msTaken;
    pop     = reset && smValid && smTaken;
    pop_val = {smData, smID};
    @(posedge clock);
    edge_n++;
    if (pop) begin
      log_q.push_back(pop_val);
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(stamp_q.pop_front());
      end
    end
    if (acc) begin
      acc_count++;
      exp_q.push_back({model_resp(a, d, w), id});
      stamp_q.push_back(edge_n);
      off = a - BASE;
      if (w && off < 32'(DEPTH)) mdl_mem[off[5:0]] = d;
    end
  endtask

  task automatic idle(input int n, input logic take);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 24'h0, 8'h0, take);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset = 1'b0; msValid = 1'b0; smTaken = 1'b0;
    #1;
    check("async reset smValid", 64'(smValid), 64'(0));
    check("async reset busy", 64'(busy), 64'(0));
    check("async reset msTaken", 64'(msTaken), 64'(0));
    exp_q.delete();
    stamp_q.delete();
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("msTaken after release", 64'(msTaken), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0;
    int id_n;
    int log_before;

    repeat (3) @(negedge clock);
    #1;
    reset = 1'b1;

    // Fill storage with known contents.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, BASE + 32'(i), init_val(i), 8'(i), 1'b1);
    idle(4, 1'b1);

    // Write then read the same word; read response one cycle after acceptance.
    log_q.delete();
    step(1'b1, 1'b1, BASE + 32'd5, 24'h123456, 8'h11, 1'b1);
    step(1'b1, 1'b0, BASE + 32'd5, 24'h000000, 8'h22, 1'b1);
    #1;
    check("wr resp visible", 64'({smValid, smData, smID}), 64'({1'b1, 24'h123456, 8'h11}));
    step(1'b0, 1'b0, 32'h0, 24'h0, 8'h0, 1'b1);
    #1;
    check("rd resp latency", 64'({smValid, smData, smID}), 64'({1'b1, 24'h123456, 8'h22}));
    idle(3, 1'b1);
    check("wr/rd count", 64'(log_q.size()), 64'(2));
    if (log_q.size() == 2) begin
      check("wr resp", 64'(log_q[0]), 64'({24'h123456, 8'h11}));
      check("rd resp", 64'(log_q[1]), 64'({24'h123456, 8'h22}));
    end

    // Out-of-range read and write below BASE.
    log_q.delete();
    step(1'b1, 1'b0, BASE + 32'(DEPTH), 24'h0, 8'h33, 1'b1);
    step(1'b1, 1'b0, BASE, 24'h0, 8'h34, 1'b1);
    step(1'b1, 1'b1, BASE - 32'd1, 24'h000000, 8'h35, 1'b1);
    step(1'b1, 1'b0, BASE, 24'h0, 8'h36, 1'b1);
    step(1'b1, 1'b0, BASE + 32'(DEPTH - 1), 24'h0, 8'h37, 1'b1);
    idle(4, 1'b1);
    check("oor count", 64'(log_q.size()), 64'(5));
    if (log_q.size() == 5) begin
      check("oor read", 64'(log_q[0]), 64'({24'hFFFFFF, 8'h33}));
      check("word0 before", 64'(log_q[1]), 64'({24'h5A0000, 8'h34}));
      check("oor write echo", 64'(log_q[2]), 64'({24'h000000, 8'h35}));
      check("word0 after", 64'(log_q[3]), 64'({24'h5A0000, 8'h36}));
      check("word last", 64'(log_q[4]), 64'({24'h653F3F, 8'h37}));
    end

    // Backpressure: queue capacity, one pop, one more acceptance.
    log_q.delete();
    a0 = acc_count;
    id_n = 8'h40;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, BASE + 32'd5, 24'h0, 8'(id_n), 1'b0);
      if (acc) id_n++;
    end
    check("full accept count", 64'(acc_count - a0), 64'(QDEPTH));
    #1;
    check("full msTaken low", 64'(msTaken), 64'(0));
    step(1'b1, 1'b0, BASE + 32'd5, 24'h0, 8'(id_n), 1'b1);
    check("no accept on pop edge", 64'(acc_count - a0), 64'(QDEPTH));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, BASE + 32'd5, 24'h0, 8'(id_n), 1'b0);
      if (acc) id_n++;
    end
    check("accept after pop", 64'(acc_count - a0), 64'(QDEPTH + 1));
    idle(8, 1'b1);
    check("bp log size", 64'(log_q.size()), 64'(QDEPTH + 1));
    for (int i = 0; i < log_q.size(); i++) check("bp id order", 64'(log_q[i][7:0]), 64'(8'h40 + i));

    // Back-to-back reads, full throughput.
    log_q.delete();
    a0 = acc_count;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, BASE + 32'(i), 24'h0, 8'(i), 1'b1);
    check("b2b accepts", 64'(acc_count - a0), 64'(16));
    check("b2b pops in window", 64'(log_q.size()), 64'(14));
    idle(2, 1'b1);
    check("b2b pops total", 64'(log_q.size()), 64'(16));
    for (int i = 0; i < log_q.size(); i++) check("b2b id order", 64'(log_q[i][7:0]), 64'(i));

    // Reset with responses queued; storage survives.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, BASE + 32'd5, 24'h0, 8'(8'h50 + i), 1'b0);
    idle(1, 1'b0);
    #1;
    check("queued smValid", 64'(smValid), 64'(1));
    check("queued busy", 64'(busy), 64'(1));
    do_reset();
    log_q.delete();
    step(1'b1, 1'b0, BASE + 32'd5, 24'h0, 8'h60, 1'b1);
    idle(3, 1'b1);
    check("post reset count", 64'(log_q.size()), 64'(1));
    if (log_q.size() == 1) check("post reset read", 64'(log_q[0]), 64'({24'h123456, 8'h60}));

    // Randomized traffic with stalls on both sides.
    log_before = log_q.size();
    for (int n = 0; n < 10000; n++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = BASE + 32'($urandom_range(0, DEPTH - 1));
      else if (sel == 6) a = BASE + 32'(DEPTH) + 32'($urandom_range(0, 100));
      else if (sel == 7) a = BASE - 32'($urandom_range(1, 100));
      else               a = $urandom;
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, 24'($urandom),
           8'($urandom), $urandom_range(0, 3) != 0);
    end
    idle(8, 1'b1);
    check("random drained", 64'(exp_q.size()), 64'(0));
    check("random progress", 64'(log_q.size() > log_before + 1000), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
